// File: rtl/voice_scheduler_pkg.sv
// Shared music definitions: note/duration widths, voice index width,
// scheduler FSM encoding and a small one-hot helper.
package voice_scheduler_pkg;

  localparam int MUSIC_NOTE_W = 6;
  localparam int MUSIC_DUR_W  = 6;
  // Voice indices and age ranks fit in two bits for up to four voices.
  localparam int IDX_W        = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2
  } sched_state_e;

  // Expand a voice index into a four-bit one-hot vector.
  function automatic logic [3:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    idx_to_onehot = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/voice_scheduler_age_tracker.sv
// Per-voice busy flags and age ranks (0 newest .. NUM_VOICES-1 oldest).
// Reports the lowest free voice and the oldest voice for target selection.
module voice_age_tracker
  import voice_scheduler_pkg::*;
#(
  parameter int NUM_VOICES = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_VOICES-1:0] load_onehot,
  input  logic [NUM_VOICES-1:0] voice_done,
  output logic [NUM_VOICES-1:0] voice_active,
  output logic [IDX_W-1:0]      free_idx,
  output logic                  any_free,
  output logic [IDX_W-1:0]      oldest_idx
);

  logic [NUM_VOICES-1:0] active_q, active_d;
  logic [IDX_W-1:0]      rank_q [NUM_VOICES];
  logic [IDX_W-1:0]      rank_d [NUM_VOICES];
  logic [IDX_W-1:0]      load_rank_s;
  logic                  load_any_s;

  assign voice_active = active_q;

  // Lowest-index idle voice; scan downward so the lowest index wins.
  always_comb begin
    free_idx = '0;
    any_free = 1'b0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (!active_q[i]) begin
        free_idx = IDX_W'(i);
        any_free = 1'b1;
      end else begin
        free_idx = free_idx;
      end
    end
  end

  // Locate the oldest voice and the rank of the voice being loaded.
  always_comb begin
    oldest_idx  = '0;
    load_rank_s = '0;
    load_any_s  = |load_onehot;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (rank_q[i] == IDX_W'(NUM_VOICES - 1)) begin
        oldest_idx = IDX_W'(i);
      end else begin
        oldest_idx = oldest_idx;
      end
      if (load_onehot[i]) begin
        load_rank_s = rank_q[i];
      end else begin
        load_rank_s = load_rank_s;
      end
    end
  end

  // Next ranks and busy flags; a load beats a same-cycle done.
  always_comb begin
    active_d = (active_q & ~voice_done) | load_onehot;
    for (int i = 0; i < NUM_VOICES; i++) begin
      rank_d[i] = rank_q[i];
      if (load_onehot[i]) begin
        rank_d[i] = '0;
      end else if (load_any_s && (rank_q[i] < load_rank_s)) begin
        rank_d[i] = rank_q[i] + IDX_W'(1);
      end else begin
        rank_d[i] = rank_q[i];
      end
    end
  end

  // State registers; ranks restart as voice k = rank k.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        rank_q[i] <= IDX_W'(i);
      end
    end else begin
      active_q <= active_d;
      for (int i = 0; i < NUM_VOICES; i++) begin
        rank_q[i] <= rank_d[i];
      end
    end
  end

endmodule

// File: rtl/voice_scheduler.sv
// Voice scheduler: accepts note / time-advance words, assigns notes to free
// voices (stealing the oldest when all are busy) and gates musical time.
module voice_scheduler
  import voice_scheduler_pkg::*;
#(
  parameter int NUM_VOICES = 3,
  parameter int NOTE_W     = MUSIC_NOTE_W,
  parameter int DUR_W      = MUSIC_DUR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  play_enable,
  input  logic                  beat,
  input  logic                  word_valid,
  input  logic                  word_is_advance,
  input  logic [NOTE_W-1:0]     word_note,
  input  logic [DUR_W-1:0]      word_duration,
  output logic                  word_ready,
  input  logic [NUM_VOICES-1:0] voice_done,
  output logic [NUM_VOICES-1:0] voice_load,
  output logic [NOTE_W-1:0]     voice_note,
  output logic [DUR_W-1:0]      voice_duration,
  output logic [NUM_VOICES-1:0] voice_active,
  output logic                  steal_event,
  output logic                  advance_time
);

  sched_state_e          state_q, state_d;
  logic [DUR_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic [NUM_VOICES-1:0] voice_load_q, voice_load_d;
  logic [NOTE_W-1:0]     voice_note_q, voice_note_d;
  logic [DUR_W-1:0]      voice_duration_q, voice_duration_d;
  logic                  steal_q, steal_d;
  logic                  advance_q, advance_d;

  logic                  accept_s;
  logic [IDX_W-1:0]      free_idx_s, oldest_idx_s, target_s;
  logic                  any_free_s;

  voice_age_tracker #(
    .NUM_VOICES (NUM_VOICES)
  ) u_age (
    .clk          (clk),
    .reset        (reset),
    .load_onehot  (voice_load),
    .voice_done   (voice_done),
    .voice_active (voice_active),
    .free_idx     (free_idx_s),
    .any_free     (any_free_s),
    .oldest_idx   (oldest_idx_s)
  );

  // A reset landing on the load cycle must not leak the pending strobe.
  assign word_ready     = (state_q == ST_IDLE) & play_enable & ~reset;
  assign accept_s       = word_valid & word_ready;
  assign target_s       = any_free_s ? free_idx_s : oldest_idx_s;
  assign voice_load     = voice_load_q & {NUM_VOICES{~reset}};
  assign steal_event    = steal_q & ~reset;
  assign voice_note     = voice_note_q;
  assign voice_duration = voice_duration_q;
  assign advance_time   = advance_q & play_enable;

  // Next-state and registered-output logic for the scheduling FSM.
  always_comb begin
    state_d          = state_q;
    beat_cnt_d       = beat_cnt_q;
    voice_load_d     = '0;
    voice_note_d     = '0;
    voice_duration_d = '0;
    steal_d          = 1'b0;
    advance_d        = advance_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && (word_duration != '0)) begin
          if (!word_is_advance) begin
            voice_load_d     = NUM_VOICES'(idx_to_onehot(target_s));
            voice_note_d     = word_note;
            voice_duration_d = word_duration;
            steal_d          = ~any_free_s;
            state_d          = ST_LOAD;
          end else begin
            beat_cnt_d = word_duration;
            advance_d  = 1'b1;
            state_d    = ST_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_d = ST_IDLE;
      end
      ST_WAIT: begin
        if (beat && play_enable) begin
          if (beat_cnt_q == DUR_W'(1)) begin
            beat_cnt_d = '0;
            advance_d  = 1'b0;
            state_d    = ST_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q - DUR_W'(1);
          end
        end else begin
          beat_cnt_d = beat_cnt_q;
        end
      end
      default: begin
        beat_cnt_d = '0;
        advance_d  = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // FSM state, beat counter and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      beat_cnt_q       <= '0;
      voice_load_q     <= '0;
      voice_note_q     <= '0;
      voice_duration_q <= '0;
      steal_q          <= 1'b0;
      advance_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      beat_cnt_q       <= beat_cnt_d;
      voice_load_q     <= voice_load_d;
      voice_note_q     <= voice_note_d;
      voice_duration_q <= voice_duration_d;
      steal_q          <= steal_d;
      advance_q        <= advance_d;
    end
  end

endmodule

// File: tb/tb_voice_scheduler.sv
// Bench for voice_scheduler: directed scenarios plus random traffic, all
// checked cycle by cycle against a behavioural model (age list + counters).
module tb_voice_scheduler;

  localparam int NV = 3;
  localparam int NW = 6;
  localparam int DW = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          play_enable = 1'b0;
  logic          beat = 1'b0;
  logic          word_valid = 1'b0;
  logic          word_is_advance = 1'b0;
  logic [NW-1:0] word_note = '0;
  logic [DW-1:0] word_duration = '0;
  logic          word_ready;
  logic [NV-1:0] voice_done = '0;
  logic [NV-1:0] voice_load;
  logic [NW-1:0] voice_note;
  logic [DW-1:0] voice_duration;
  logic [NV-1:0] voice_active;
  logic          steal_event;
  logic          advance_time;

  always #5 clk = ~clk;

  voice_scheduler #(.NUM_VOICES(NV), .NOTE_W(NW), .DUR_W(DW)) dut (
    .clk(clk), .reset(reset), .play_enable(play_enable), .beat(beat),
    .word_valid(word_valid), .word_is_advance(word_is_advance),
    .word_note(word_note), .word_duration(word_duration),
    .word_ready(word_ready), .voice_done(voice_done),
    .voice_load(voice_load), .voice_note(voice_note),
    .voice_duration(voice_duration), .voice_active(voice_active),
    .steal_event(steal_event), .advance_time(advance_time)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: busy bits, age list (front = newest), pending load,
  // remaining beats of a time advance.
  bit m_act [NV];
  int m_age [$];
  bit m_ld;
  int m_tgt, m_note, m_dur;
  bit m_steal;
  int m_beats;

  task automatic model_reset();
    for (int i = 0; i < NV; i++) m_act[i] = 1'b0;
    m_age = {};
    for (int i = 0; i < NV; i++) m_age.push_back(i);
    m_ld = 1'b0; m_tgt = 0; m_note = 0; m_dur = 0; m_steal = 1'b0; m_beats = 0;
  endtask

  function automatic logic [31:0] act_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < NV; i++) v[i] = m_act[i];
    return v;
  endfunction

  // One clock cycle: drive, check outputs against the model, advance model.
  task automatic tick(input bit rst, input bit pe, input bit bt, input bit wv,
                      input bit adv, input int note, input int dur,
                      input logic [NV-1:0] done);
    bit idle, exp_ready, accept;
    int ffree;
    logic [31:0] exp_load;
    @(negedge clk);
    reset = rst; play_enable = pe; beat = bt; word_valid = wv;
    word_is_advance = adv; word_note = NW'(note); word_duration = DW'(dur);
    voice_done = done;
    #1;
    idle      = !m_ld && (m_beats == 0);
    exp_ready = idle && pe && !rst;
    exp_load  = (m_ld && !rst) ? (32'd1 << m_tgt) : 32'd0;
    check_eq("word_ready", word_ready, exp_ready);
    check_eq("voice_load", voice_load, exp_load);
    check_eq("steal_event", steal_event, m_ld && !rst && m_steal);
    if (m_ld && !rst) begin
      check_eq("voice_note", voice_note, m_note);
      check_eq("voice_duration", voice_duration, m_dur);
    end
    check_eq("voice_active", voice_active, act_vec());
    check_eq("advance_time", advance_time, (m_beats > 0) && pe);
    if (rst) begin
      model_reset();
    end else begin
      accept = wv && exp_ready;
      ffree = -1;
      for (int i = 0; i < NV; i++) if (!m_act[i] && ffree < 0) ffree = i;
      for (int i = 0; i < NV; i++) if (done[i]) m_act[i] = 1'b0;
      if (m_ld) begin
        m_act[m_tgt] = 1'b1;
        for (int j = 0; j < m_age.size(); j++) begin
          if (m_age[j] == m_tgt) begin
            m_age.delete(j);
            break;
          end
        end
        m_age.push_front(m_tgt);
        m_ld = 1'b0;
      end else if (m_beats > 0) begin
        if (pe && bt) m_beats--;
      end else if (accept && dur != 0) begin
        if (!adv) begin
          m_ld    = 1'b1;
          m_tgt   = (ffree >= 0) ? ffree : m_age[m_age.size()-1];
          m_steal = (ffree < 0);
          m_note  = note;
          m_dur   = dur;
        end else begin
          m_beats = dur;
        end
      end
    end
  endtask

  task automatic idle_tick();
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, '0);
  endtask

  initial begin
    model_reset();
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, '0);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, '0);

    // Three back-to-back notes fill voices 0, 1, 2.
    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10, 4, '0); idle_tick();
    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 12, 4, '0); idle_tick();
    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 14, 4, '0); idle_tick();
    idle_tick();
    check_eq("three_active", voice_active, 32'd7);

    // All busy: steal voice 0, then voice 1 with a same-cycle done on it.
    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 20, 2, '0);
    idle_tick();
    check_eq("steal_v0_load", voice_load, 32'd1);
    check_eq("steal_v0_flag", steal_event, 32'd1);
    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 22, 2, '0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 3'b010);
    check_eq("steal_v1_load", voice_load, 32'd2);
    idle_tick();
    check_eq("load_wins_done", voice_active, 32'd7);

    // Advance of 3 beats, beats every 50 cycles, two beats lost to a pause.
    for (int c = 0; c < 260; c++) begin
      tick(1'b0, !(c >= 60 && c < 160), (c % 50) == 49, c == 0, 1'b1, 0, 3, '0);
    end
    check_eq("adv_done_ready", word_ready, 32'd1);
    check_eq("adv_done_time", advance_time, 32'd0);

    // Zero-duration words are consumed silently; reset kills a pending load.
    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5, 0, 3'b111);
    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0, '0);
    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 30, 3, '0);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, '0);
    check_eq("rst_load_sup", voice_load, 32'd0);
    idle_tick();
    check_eq("post_rst_active", voice_active, 32'd0);
    check_eq("post_rst_note", voice_note, 32'd0);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      bit r_adv;
      int r_dur;
      r_adv = ($urandom % 4) == 0;
      r_dur = r_adv ? int'($urandom % 5) : int'($urandom % 8);
      tick(($urandom % 200) == 0, ($urandom % 8) != 0, ($urandom % 4) == 0,
           $urandom % 2, r_adv, int'($urandom % 64), r_dur,
           (($urandom % 6) == 0) ? NV'($urandom) : NV'(0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/voice_scheduler.md
# voice_scheduler

Sequencing controller between the song word stream and the bank of note players. It accepts note and time-advance words over a valid/ready handshake and assigns each note to a free player voice, stealing the oldest voice when all are busy. It gates musical time by holding `advance_time` for the requested number of beats. It replaces fixed-slot note arrangement and drives the players' load strobes and play enable.

## Interface
Parameters:
- `NUM_VOICES`, 3: number of note players scheduled; legal range 2..4.
- `NOTE_W`, 6: note value width.
- `DUR_W`, 6: duration width, in beats.

Ports:
- `clk`  in  1  system clock; the block uses a single clock.
- `reset`  in  1  synchronous, active-high reset.
- `play_enable`  in  1  from the MCU. Low pauses scheduling and beat counting.
- `beat`  in  1  one-cycle beat strobe from `beat_generator`.
- `word_valid`  in  1  input word present.
- `word_is_advance`  in  1  1 = time-advance word, 0 = note word.
- `word_note`  in  NOTE_W  note value; ignored for advance words.
- `word_duration`  in  DUR_W  note length, or beats to wait for an advance word.
- `word_ready`  out  1  combinational. It is high when state is IDLE and `play_enable` is high.
- `voice_done`  in  NUM_VOICES  per-player one-cycle done pulses.
- `voice_load`  out  NUM_VOICES  one-hot, one-cycle load strobe.
- `voice_note`  out  NOTE_W  shared load bus. Valid while `voice_load` is nonzero.
- `voice_duration`  out  DUR_W  shared load bus. Valid while `voice_load` is nonzero.
- `voice_active`  out  NUM_VOICES  per-voice busy flags.
- `steal_event`  out  1  pulses together with `voice_load` when the target voice was active.
- `advance_time`  out  1  play enable for all note players.

## Operation
FSM states: IDLE, LOAD, WAIT.

IDLE:
- A word is accepted on `word_valid & word_ready`.
- Note word with duration ≠ 0: latch note, duration and target voice, then go to LOAD.
- Note word with duration 0: consume and drop; stay in IDLE.
- Advance word with duration ≠ 0: load `beat_cnt` = duration, then go to WAIT.
- Advance word with duration 0: consume; stay in IDLE.

LOAD:
- Registered outputs present the latched note: `voice_load[target]`=1, `voice_note`, `voice_duration`.
- `steal_event`=1 if the target voice was active.
- Return to IDLE next cycle.

WAIT:
- `advance_time` = `play_enable`.
- On `beat & play_enable`, decrement `beat_cnt`.
- When `beat_cnt`==1 and a qualified beat arrives, return to IDLE.

Target selection, decided at accept time:
- Lowest-index voice whose `voice_active` bit is 0.
- If none is free, the voice whose age rank equals NUM_VOICES-1 (the oldest).

Age ranks:
- Each voice holds a distinct rank, 0 (newest) to NUM_VOICES-1 (oldest).
- On a load of voice k with rank r: every voice with rank < r increments, and k takes rank 0.

`voice_active` updates:
- Set by `voice_load`.
- Cleared by `voice_done`.
- If load and done hit the same voice in the same cycle, load wins and the bit stays 1.

Pausing:
- `play_enable` low freezes the FSM in IDLE or WAIT, and freezes `beat_cnt`.
- A pending LOAD still completes.

## Timing
- Reset values: state IDLE; `voice_load`, `voice_note`, `voice_duration`, `voice_active`, `steal_event`, `advance_time`, `beat_cnt` all 0. Ranks initialise to voice k = rank k.
- `word_ready` is low during the reset cycle.
- Note latency: accept in cycle t, `voice_load` in cycle t+1, `word_ready` high again in t+2. Maximum throughput is one note per 2 cycles.
- Advance: `advance_time` rises in cycle t+1. It falls in the cycle after the final qualified beat, which is the same cycle `word_ready` returns high.
- A beat in the accept cycle is not counted.
- A `voice_done` in the accept cycle is visible to target selection only from the next accept onward. Selection uses registered `voice_active`.
- Reset mid-LOAD suppresses the pending `voice_load`.
- Reset mid-WAIT drops `advance_time` in the next cycle.

## Structure
- Shared package/include `music_defs`: FSM state encodings, and `NOTE_W`/`DUR_W` constants shared with `song_reader` and `note_player`.
- One sub-module, `voice_age_tracker`:
  - Holds the ranks and the `voice_active` bits.
  - Outputs `free_idx`, `any_free` and `oldest_idx`.
  - Inputs are `load_onehot` and `voice_done`.
- The FSM, `beat_cnt` and output registers stay in the top module.

## Test plan
- Reset, then `play_enable`=1 and three notes (10,4), (12,4), (14,4) back-to-back → `voice_load` = 001, 010, 100 in cycles 1, 3, 5. `voice_active`=111. `steal_event` never asserts.
- All active, then note (20,2) → `voice_load`=001 with `steal_event`=1. Next note (22,2) → steals voice 1 (`voice_load`=010).
- `voice_done`=010 in the same cycle as a load of voice 1 → `voice_active[1]` remains 1.
- Advance word duration 3, beats every 50 cycles → `advance_time` high for exactly 3 beats. `word_ready` returns 1 cycle after the third beat.
- Mid-WAIT, drop `play_enable` across 2 beats → `advance_time`=0, `beat_cnt` frozen. Total qualified beats stay 3.
- Note with duration 0, advance with duration 0, and reset asserted in a LOAD cycle → no `voice_load` pulses. All outputs 0 the cycle after reset.
